// File: rtl/cond_code_unit.sv
// Execute-stage condition-code unit for the pipelined Y86-64 core.
// Holds the architectural CC register (ZF, SF, OF) and evaluates the
// cmovXX/jXX condition from it. The result is registered into the E->M
// pipeline boundary. A sticky FROZEN state stops CC updates once an
// exception has reached M/W; only reset leaves FROZEN.
module cond_code_unit #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] alu_result,
    input  logic         alu_of,
    input  logic         set_cc_en,
    input  logic         exc_in,
    input  logic         stall_m,
    input  logic         bubble_m,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic         e_cnd,
    output logic         M_cnd,
    output logic         frozen
);

    localparam logic [3:0] ICODE_CMOV = 4'h2;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] ICODE_JXX  = 4'h7;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   zf_q, zf_d;
    logic   sf_q, sf_d;
    logic   of_q, of_d;
    logic   m_cnd_q, m_cnd_d;
    logic   cc_we;
    logic   less;

    // Next state: any exception while running freezes; FROZEN only exits on reset.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && exc_in) begin
            state_d = ST_FROZEN;
        end
    end

    // CC next value: only an OPq in RUN with no exception, enabled and not stalled writes CC.
    always_comb begin
        zf_d  = zf_q;
        sf_d  = sf_q;
        of_d  = of_q;
        cc_we = (state_q == ST_RUN) && !exc_in && set_cc_en && !stall_m &&
                (E_icode == ICODE_OPQ);
        if (cc_we) begin
            zf_d = (alu_result == '0);
            sf_d = alu_result[W-1];
            of_d = alu_of;
        end
    end

    // Condition evaluation from the current (pre-update) CC value.
    always_comb begin
        e_cnd = 1'b0;
        less  = sf_q ^ of_q;
        if (E_icode == ICODE_CMOV || E_icode == ICODE_JXX) begin
            case (E_ifun)
                4'h0:    e_cnd = 1'b1;
                4'h1:    e_cnd = less | zf_q;
                4'h2:    e_cnd = less;
                4'h3:    e_cnd = zf_q;
                4'h4:    e_cnd = ~zf_q;
                4'h5:    e_cnd = ~less;
                4'h6:    e_cnd = ~less & ~zf_q;
                default: e_cnd = 1'b0;
            endcase
        end
    end

    // E->M condition register: stall holds (and wins over bubble), bubble clears.
    always_comb begin
        m_cnd_d = e_cnd;
        if (stall_m) begin
            m_cnd_d = m_cnd_q;
        end else if (bubble_m) begin
            m_cnd_d = 1'b0;
        end
    end

    // State register; reset overrides everything, including a pending freeze.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            m_cnd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            m_cnd_q <= m_cnd_d;
        end
    end

    assign cc_zf  = zf_q;
    assign cc_sf  = sf_q;
    assign cc_of  = of_q;
    assign M_cnd  = m_cnd_q;
    assign frozen = (state_q == ST_FROZEN);

endmodule

// File: doc/cond_code_unit.md
Name: cond_code_unit

Overview:
- Execute-stage condition-code unit for the pipelined Y86-64 core; consumes the 64-bit ALU result and overflow flag produced by the ALU adder/subtractor.
- Holds the architectural CC register (ZF, SF, OF) and evaluates cmovXX/jXX conditions from it.
- Registers the evaluated condition into the E->M pipeline boundary.
- Provides a sticky freeze state so CC stops changing once an exception reaches M/W.

Parameters:
- W, 64, ALU datapath width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk.
- E_icode  input  4  instruction code in Execute.
- E_ifun  input  4  function code in Execute.
- alu_result  input  W  ALU output for the Execute instruction.
- alu_of  input  1  ALU signed-overflow flag.
- set_cc_en  input  1  pipeline control permits CC update this cycle.
- exc_in  input  1  exception present in M or W (m_stat/W_stat not AOK).
- stall_m  input  1  hold the E->M register.
- bubble_m  input  1  clear the E->M register to a bubble.
- cc_zf  output  1  registered zero flag.
- cc_sf  output  1  registered sign flag.
- cc_of  output  1  registered overflow flag.
- e_cnd  output  1  combinational condition result for the Execute instruction.
- M_cnd  output  1  registered condition, E->M pipeline register.
- frozen  output  1  1 when in FROZEN state.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - cc_zf=1, cc_sf=0, cc_of=0.
  - M_cnd=0.
  - State=RUN, so frozen=0.
  - Reset overrides every other input in that cycle, including mid-freeze.
- FSM:
  - States are RUN and FROZEN.
  - RUN->FROZEN on any clk edge with exc_in=1.
  - FROZEN is sticky until reset.
  - frozen=1 iff state is FROZEN.
- CC update:
  - Occurs at clk edge iff state=RUN, exc_in=0, set_cc_en=1, stall_m=0 and E_icode=4'h6 (OPq).
  - zf <= (alu_result==0); sf <= alu_result[W-1]; of <= alu_of.
  - Otherwise CC holds.
  - If exc_in=1 in the same cycle as an OPq, the update is suppressed and the state still enters FROZEN.
- e_cnd:
  - Combinational from the current registered CC, i.e. the value before any update this edge.
  - Valid only for E_icode=4'h2 (rrmovq/cmovXX) or 4'h7 (jXX); for all other icodes e_cnd=0.
  - ifun 0: 1.
  - ifun 1 (le): (sf^of)|zf.
  - ifun 2 (l): sf^of.
  - ifun 3 (e): zf.
  - ifun 4 (ne): ~zf.
  - ifun 5 (ge): ~(sf^of).
  - ifun 6 (g): ~(sf^of)&~zf.
  - ifun 7..15: 0.
- M_cnd (latency 1):
  - stall_m=1: hold.
  - Else bubble_m=1: 0.
  - Else: e_cnd.
  - When stall_m and bubble_m are both 1, stall wins and the register holds.
  - M_cnd keeps updating in FROZEN; only CC freezes.
- Boundary results:
  - alu_result=0 with alu_of=1 yields zf=1, of=1.
  - alu_result=64'h8000_0000_0000_0000 yields sf=1, zf=0.
  - No width truncation; zf examines all W bits.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 one cycle, then E_icode=7, ifun=3.
  - Response: cc={zf1,sf0,of0}, e_cnd=1, M_cnd=1 next cycle, frozen=0.
- OPq update:
  - Stimulus: icode=6, set_cc_en=1, alu_result=64'hFFFF_FFFF_FFFF_FFFF, alu_of=0.
  - Response: next cycle zf=0, sf=1, of=0; then jl (icode7, ifun2) gives e_cnd=1 and jg (ifun6) gives e_cnd=0.
- Overflow path:
  - Stimulus: alu_result=64'h8000_0000_0000_0000, alu_of=1.
  - Response: sf=1, of=1; jge gives e_cnd=1; jl gives e_cnd=0.
- Exception freeze:
  - Stimulus: OPq with alu_result=5 and exc_in=1 in the same cycle.
  - Response: CC unchanged, frozen=1. Subsequent OPq with alu_result=0 and exc_in=0 leaves CC unchanged. Assert rst_n=0 and frozen returns to 0.
- set_cc_en gating:
  - Stimulus: OPq with alu_result=0, set_cc_en=0.
  - Response: zf unchanged. Repeat with set_cc_en=1 and stall_m=1: zf unchanged.
- Pipeline control:
  - Stimulus: M_cnd=1, then stall_m=1 with e_cnd=0; then bubble_m=1; then stall_m=bubble_m=1 with e_cnd=1.
  - Response: M_cnd reads 1 (held), then 0 (bubble), then 0 (held, stall wins).
  - Also check icode=3 with ifun=0 gives e_cnd=0.
